regfile_write_scheduler: RTL and testbench
==========================================

Name: regfile_write_scheduler

Overview:
- Sits between the two result sources and the 16x16 register file.
  - Source A is EX/ALU. It can issue single writes, or dual writes for mul/div (Rd plus R0).
  - Source B is MEM, which issues load writes (always single).
- Arbitrates both sources onto the register file's single write command (RegWrite/WriteReg1/WriteData1/WriteData2) and registers that command.
- Keeps a 16-bit pending-write scoreboard (Busy) that decode uses for RAW stalls.

Parameters:
- DATA_W, 16, data width of every write payload.
- NREG, 16, number of architectural registers; scoreboard width.
- REG_W, 4, register index width (log2 NREG).
- FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = A always wins a conflict.

Ports:
- CLOCK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- ResvValid  in  1  decode reserves a destination this cycle.
- ResvReg  in  REG_W  destination being reserved.
- ResvDual  in  1  also reserve R0 (mul/div).
- A_Valid  in  1  EX write request.
- A_Ready  out  1  EX request granted this cycle.
- A_Reg  in  REG_W  EX destination.
- A_Dual  in  1  EX request is a dual write.
- A_Data  in  DATA_W  EX primary result.
- A_Data2  in  DATA_W  EX secondary result, written to R0 when A_Dual.
- B_Valid  in  1  MEM write request.
- B_Ready  out  1  MEM request granted this cycle.
- B_Reg  in  REG_W  MEM destination.
- B_Data  in  DATA_W  MEM load data.
- RegWrite  out  2  0 = none, 1 = WriteReg1<-WriteData1, 2 = WriteReg1<-WriteData1 and R0<-WriteData2.
- WriteReg1  out  REG_W  write destination.
- WriteReg2  out  REG_W  tied to 0.
- WriteData1  out  DATA_W  primary write data.
- WriteData2  out  DATA_W  R0 write data (dual writes only).
- Busy  out  NREG  scoreboard; bit i = write to Ri pending.
- ErrUnreserved  out  1  sticky; set when a write commits to a register whose Busy bit was clear.

Behaviour:
- Reset (RESET low, asynchronous):
  - RegWrite=0; WriteReg1, WriteData1, WriteData2 = 0; Busy=0; ErrUnreserved=0.
  - Last-grant pointer = B, so A wins the first conflict.
  - A_Ready and B_Ready are held 0 while RESET is low.
- Grant logic is combinational and depends only on the valids and the pointer.
  - Only A valid: A_Ready=1.
  - Only B valid: B_Ready=1.
  - Both valid: the one not last granted wins. With FIXED_PRIO=1, A always wins.
  - At most one Ready is high per cycle. Ready is never high without its Valid.
- A requester must hold Valid, Reg and Data stable until it sees Ready.
- Pointer updates on every grant.
- Command register, loaded at the edge ending a grant cycle:
  - Grant A, A_Dual=0: RegWrite=1, WriteReg1=A_Reg, WriteData1=A_Data.
  - Grant A, A_Dual=1: RegWrite=2, WriteData2=A_Data2.
  - Grant B: RegWrite=1, WriteReg1=B_Reg, WriteData1=B_Data.
  - No grant: RegWrite=0. Data and index registers hold their previous value.
- Latency: the command is valid 1 cycle after the grant. The register file commits at the edge after that, so the value is readable 2 edges after the grant.
- Scoreboard commit: a cycle with RegWrite!=0 clears Busy[WriteReg1], and also Busy[0] when RegWrite=2, at that cycle's closing edge.
- Reservation: ResvValid sets Busy[ResvReg], and Busy[0] if ResvDual, at the same edge.
- Same register set and cleared in one cycle: set wins, so Busy stays 1 (new in-flight write).
- Committing with Busy bit already 0 sets ErrUnreserved. The write is still performed. The flag clears only on reset.
- WriteReg1=0 with RegWrite=1 is legal: R0 is an ordinary target.
- Reset mid-transfer: the pending command is dropped (RegWrite forced 0), the scoreboard is cleared, and requesters must re-present.

Test Plan:
- Reset, then A_Valid with A_Reg=8, A_Data=16'hC78A, after ResvReg=8 -> A_Ready=1 same cycle; next cycle RegWrite=1, WriteReg1=8, WriteData1=C78A; Busy[8] goes 1 then 0 after the commit edge.
- Both valid (A_Reg=3/1111, B_Reg=5/2222) for 3 consecutive cycles with requests re-presented -> grant order A, B, A. With FIXED_PRIO=1 -> A, A, A.
- A dual: A_Reg=3, A_Data=16'h3251, A_Data2=16'hAABB, after Resv 3 with ResvDual -> RegWrite=2, WriteData2=AABB; Busy[3] and Busy[0] clear together.
- ResvReg=5 in the same cycle RegWrite=1 commits WriteReg1=5 -> Busy[5] stays 1; ErrUnreserved stays 0.
- B commits to R7 with no reservation -> write occurs and ErrUnreserved=1, staying 1 through later traffic until RESET low.
- Assert RESET low for one cycle while a command is pending (RegWrite=1) -> outputs and Busy go 0 immediately; no regfile write after reset release.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// rtl/regfile_write_scheduler.sv - arbitrates EX/MEM result writes onto the register file and tracks pending writes
module regfile_write_scheduler #(
  parameter int DATA_W     = 16,
  parameter int NREG       = 16,
  parameter int REG_W      = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              ResvValid,
  input  logic [REG_W-1:0]  ResvReg,
  input  logic              ResvDual,
  input  logic              A_Valid,
  output logic              A_Ready,
  input  logic [REG_W-1:0]  A_Reg,
  input  logic              A_Dual,
  input  logic [DATA_W-1:0] A_Data,
  input  logic [DATA_W-1:0] A_Data2,
  input  logic              B_Valid,
  output logic              B_Ready,
  input  logic [REG_W-1:0]  B_Reg,
  input  logic [DATA_W-1:0] B_Data,
  output logic [1:0]        RegWrite,
  output logic [REG_W-1:0]  WriteReg1,
  output logic [REG_W-1:0]  WriteReg2,
  output logic [DATA_W-1:0] WriteData1,
  output logic [DATA_W-1:0] WriteData2,
  output logic [NREG-1:0]   Busy,
  output logic              ErrUnreserved
);

  // Set when the most recent grant went to A; reset value points at B so A wins the first conflict.
  logic            lastGrantA;
  logic            grantA;
  logic            grantB;
  logic [NREG-1:0] commitMask;
  logic [NREG-1:0] resvMask;
  logic            unreservedHit;

  assign WriteReg2 = '0;
  assign A_Ready   = grantA;
  assign B_Ready   = grantB;

  // Grant: depends only on valids and the last-grant pointer; both Readys held low during reset.
  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    if (RESET) begin
      if (A_Valid && (!B_Valid || (FIXED_PRIO != 0) || !lastGrantA)) begin
        grantA = 1'b1;
      end else if (B_Valid) begin
        grantB = 1'b1;
      end
    end
  end

  // Scoreboard masks: registers retired by the command in flight and registers reserved by decode.
  always_comb begin
    commitMask = '0;
    resvMask   = '0;
    if (RegWrite != 2'd0) begin
      commitMask[WriteReg1] = 1'b1;
    end
    if (RegWrite == 2'd2) begin
      commitMask[0] = 1'b1;
    end
    if (ResvValid) begin
      resvMask[ResvReg] = 1'b1;
      if (ResvDual) begin
        resvMask[0] = 1'b1;
      end
    end
    unreservedHit = |(commitMask & ~Busy);
  end

  // Command register, pointer, scoreboard and sticky error; a reservation overrides a same-cycle retire.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      RegWrite      <= 2'd0;
      WriteReg1     <= '0;
      WriteData1    <= '0;
      WriteData2    <= '0;
      Busy          <= '0;
      ErrUnreserved <= 1'b0;
      lastGrantA    <= 1'b0;
    end else begin
      Busy <= (Busy & ~commitMask) | resvMask;
      if (unreservedHit) begin
        ErrUnreserved <= 1'b1;
      end
      if (grantA) begin
        lastGrantA <= 1'b1;
        RegWrite   <= A_Dual ? 2'd2 : 2'd1;
        WriteReg1  <= A_Reg;
        WriteData1 <= A_Data;
        if (A_Dual) begin
          WriteData2 <= A_Data2;
        end
      end else if (grantB) begin
        lastGrantA <= 1'b0;
        RegWrite   <= 2'd1;
        WriteReg1  <= B_Reg;
        WriteData1 <= B_Data;
      end else begin
        RegWrite <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb/tb_regfile_write_scheduler.sv - randomized self-checking bench for regfile_write_scheduler
module tb_regfile_write_scheduler;

  logic        CLOCK;
  logic        RESET;
  logic        ResvValid;
  logic [3:0]  ResvReg;
  logic        ResvDual;
  logic        A_Valid;
  logic [3:0]  A_Reg;
  logic        A_Dual;
  logic [15:0] A_Data;
  logic [15:0] A_Data2;
  logic        B_Valid;
  logic [3:0]  B_Reg;
  logic [15:0] B_Data;

  logic        A_Ready, B_Ready;
  logic [1:0]  RegWrite;
  logic [3:0]  WriteReg1, WriteReg2;
  logic [15:0] WriteData1, WriteData2;
  logic [15:0] Busy;
  logic        ErrUnreserved;

  logic        fA_Ready, fB_Ready;
  logic [1:0]  fRegWrite;
  logic [3:0]  fWriteReg1, fWriteReg2;
  logic [15:0] fWriteData1, fWriteData2;
  logic [15:0] fBusy;
  logic        fErrUnreserved;

  regfile_write_scheduler #(.FIXED_PRIO(0)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .ResvValid(ResvValid), .ResvReg(ResvReg), .ResvDual(ResvDual),
    .A_Valid(A_Valid), .A_Ready(A_Ready), .A_Reg(A_Reg), .A_Dual(A_Dual),
    .A_Data(A_Data), .A_Data2(A_Data2),
    .B_Valid(B_Valid), .B_Ready(B_Ready), .B_Reg(B_Reg), .B_Data(B_Data),
    .RegWrite(RegWrite), .WriteReg1(WriteReg1), .WriteReg2(WriteReg2),
    .WriteData1(WriteData1), .WriteData2(WriteData2),
    .Busy(Busy), .ErrUnreserved(ErrUnreserved)
  );

  regfile_write_scheduler #(.FIXED_PRIO(1)) dutFixed (
    .CLOCK(CLOCK), .RESET(RESET),
    .ResvValid(ResvValid), .ResvReg(ResvReg), .ResvDual(ResvDual),
    .A_Valid(A_Valid), .A_Ready(fA_Ready), .A_Reg(A_Reg), .A_Dual(A_Dual),
    .A_Data(A_Data), .A_Data2(A_Data2),
    .B_Valid(B_Valid), .B_Ready(fB_Ready), .B_Reg(B_Reg), .B_Data(B_Data),
    .RegWrite(fRegWrite), .WriteReg1(fWriteReg1), .WriteReg2(fWriteReg2),
    .WriteData1(fWriteData1), .WriteData2(fWriteData2),
    .Busy(fBusy), .ErrUnreserved(fErrUnreserved)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: expected command, pending-write set, error flag and who won last.
  int          mRW;
  int          mReg1;
  logic [15:0] mD1, mD2;
  bit          mBusy [16];
  bit          mErr;
  bit          lastWinnerIsB;
  bit          lastGA, lastGB;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] modelBusyWord();
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[i] = mBusy[i];
    return w;
  endfunction

  task automatic modelReset();
    mRW = 0; mReg1 = 0; mD1 = '0; mD2 = '0; mErr = 0;
    lastWinnerIsB = 1;
    for (int i = 0; i < 16; i++) mBusy[i] = 0;
  endtask

  // One clock: inputs already driven; compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    bit gA, gB;
    @(negedge CLOCK);
    gA = 0; gB = 0;
    if (A_Valid && B_Valid) begin
      if (lastWinnerIsB) gA = 1; else gB = 1;
    end else if (A_Valid) begin
      gA = 1;
    end else if (B_Valid) begin
      gB = 1;
    end
    checkVal("A_Ready", 32'(A_Ready), 32'(gA));
    checkVal("B_Ready", 32'(B_Ready), 32'(gB));
    checkVal("RegWrite", 32'(RegWrite), 32'(mRW));
    checkVal("WriteReg1", 32'(WriteReg1), 32'(mReg1));
    checkVal("WriteReg2", 32'(WriteReg2), 32'(0));
    checkVal("WriteData1", 32'(WriteData1), 32'(mD1));
    checkVal("WriteData2", 32'(WriteData2), 32'(mD2));
    checkVal("Busy", 32'(Busy), 32'(modelBusyWord()));
    checkVal("ErrUnreserved", 32'(ErrUnreserved), 32'(mErr));
    lastGA = gA;
    lastGB = gB;
    @(posedge CLOCK);
    if (mRW != 0) begin
      if (!mBusy[mReg1] || (mRW == 2 && !mBusy[0])) mErr = 1;
      mBusy[mReg1] = 0;
      if (mRW == 2) mBusy[0] = 0;
    end
    if (ResvValid) begin
      mBusy[ResvReg] = 1;
      if (ResvDual) mBusy[0] = 1;
    end
    if (gA) begin
      mRW = A_Dual ? 2 : 1;
      mReg1 = int'(A_Reg);
      mD1 = A_Data;
      if (A_Dual) mD2 = A_Data2;
      lastWinnerIsB = 0;
    end else if (gB) begin
      mRW = 1;
      mReg1 = int'(B_Reg);
      mD1 = B_Data;
      lastWinnerIsB = 1;
    end else begin
      mRW = 0;
    end
    #1;
  endtask

  task automatic idleInputs();
    ResvValid = 0; ResvReg = '0; ResvDual = 0;
    A_Valid = 0; A_Reg = '0; A_Dual = 0; A_Data = '0; A_Data2 = '0;
    B_Valid = 0; B_Reg = '0; B_Data = '0;
  endtask

  logic [1:0] seq [3];
  logic [1:0] fseq [3];

  initial begin
    RESET = 1'b0;
    idleInputs();
    modelReset();
    lastGA = 0; lastGB = 0;
    #3;
    checkVal("reset_RegWrite", 32'(RegWrite), 32'(0));
    checkVal("reset_Busy", 32'(Busy), 32'(0));
    checkVal("reset_Err", 32'(ErrUnreserved), 32'(0));
    A_Valid = 1; B_Valid = 1;
    #1;
    checkVal("reset_Ready", 32'({A_Ready, B_Ready}), 32'(0));
    A_Valid = 0; B_Valid = 0;
    @(posedge CLOCK);
    #1 RESET = 1'b1;

    // Conflicts: reserve R3 and R5, then both request for three cycles.
    ResvValid = 1; ResvReg = 4'd3; tick();
    ResvReg = 4'd5; tick();
    A_Valid = 1; A_Reg = 4'd3; A_Data = 16'h1111;
    B_Valid = 1; B_Reg = 4'd5; B_Data = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      ResvValid = (i == 1); ResvReg = 4'd3;
      #1;
      seq[i] = A_Ready ? 2'd1 : (B_Ready ? 2'd2 : 2'd0);
      fseq[i] = fA_Ready ? 2'd1 : (fB_Ready ? 2'd2 : 2'd0);
      tick();
    end
    checkVal("rr_order", 32'({seq[0], seq[1], seq[2]}), 32'(6'b01_10_01));
    checkVal("fixed_order", 32'({fseq[0], fseq[1], fseq[2]}), 32'(6'b01_01_01));
    idleInputs();
    tick(); tick();
    checkVal("conflict_busy_clear", 32'(Busy), 32'(0));

    // Single A write to R8.
    ResvValid = 1; ResvReg = 4'd8; tick();
    ResvValid = 0;
    checkVal("resv8_busy", 32'(Busy[8]), 32'(1));
    A_Valid = 1; A_Reg = 4'd8; A_Data = 16'hC78A; tick();
    A_Valid = 0;
    checkVal("a8_cmd", 32'({RegWrite, WriteReg1, WriteData1}), 32'({2'd1, 4'd8, 16'hC78A}));
    checkVal("a8_busy_pending", 32'(Busy[8]), 32'(1));
    tick();
    checkVal("a8_busy_cleared", 32'(Busy[8]), 32'(0));

    // Dual write: R3 plus R0.
    ResvValid = 1; ResvReg = 4'd3; ResvDual = 1; tick();
    idleInputs();
    A_Valid = 1; A_Reg = 4'd3; A_Dual = 1; A_Data = 16'h3251; A_Data2 = 16'hAABB; tick();
    A_Valid = 0;
    checkVal("dual_cmd", 32'({RegWrite, WriteReg1, WriteData2}), 32'({2'd2, 4'd3, 16'hAABB}));
    checkVal("dual_busy_set", 32'({Busy[3], Busy[0]}), 32'(2'b11));
    tick();
    checkVal("dual_busy_clear", 32'({Busy[3], Busy[0]}), 32'(2'b00));

    // Reservation coinciding with commit of the same register.
    idleInputs();
    ResvValid = 1; ResvReg = 4'd5; tick();
    ResvValid = 0;
    B_Valid = 1; B_Reg = 4'd5; B_Data = 16'h5555; tick();
    B_Valid = 0; ResvValid = 1; ResvReg = 4'd5; tick();
    ResvValid = 0;
    checkVal("set_wins_busy5", 32'(Busy[5]), 32'(1));
    checkVal("set_wins_no_err", 32'(ErrUnreserved), 32'(0));

    // Unreserved commit to R7 raises the sticky error.
    B_Valid = 1; B_Reg = 4'd7; B_Data = 16'h7777; tick();
    B_Valid = 0; tick();
    checkVal("unreserved_err", 32'(ErrUnreserved), 32'(1));

    // Random traffic with requesters that hold until granted.
    idleInputs();
    lastGA = 0; lastGB = 0;
    for (int i = 0; i < 400; i++) begin
      if (!A_Valid || lastGA) begin
        A_Valid = 1'($urandom_range(0, 1));
        A_Reg = 4'($urandom); A_Dual = ($urandom_range(0, 3) == 0);
        A_Data = 16'($urandom); A_Data2 = 16'($urandom);
      end
      if (!B_Valid || lastGB) begin
        B_Valid = 1'($urandom_range(0, 1));
        B_Reg = 4'($urandom); B_Data = 16'($urandom);
      end
      ResvValid = 1'($urandom_range(0, 1));
      ResvReg = 4'($urandom); ResvDual = ($urandom_range(0, 5) == 0);
      tick();
    end
    checkVal("err_sticky", 32'(ErrUnreserved), 32'(1));

    // Reset while a command is pending.
    idleInputs();
    A_Valid = 1; A_Reg = 4'd2; A_Data = 16'h0BAD; tick();
    checkVal("pre_reset_cmd", 32'(RegWrite), 32'(1));
    #1 RESET = 1'b0;
    #1;
    checkVal("async_RegWrite", 32'(RegWrite), 32'(0));
    checkVal("async_Busy", 32'(Busy), 32'(0));
    checkVal("async_Err", 32'(ErrUnreserved), 32'(0));
    checkVal("async_Ready", 32'(A_Ready), 32'(0));
    A_Valid = 0;
    modelReset();
    @(posedge CLOCK);
    #2 RESET = 1'b1;
    tick(); tick();
    checkVal("post_reset_idle", 32'(RegWrite), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
